mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of data, address and writeback paths.
REQ-002 SHALL have parameter REG_W, default 3: width of the register-select field.
REQ-003 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_EM  input  1  the EM latch holds a real instruction, not a bubble.
REQ-007 SHALL have port isRegWrite_EM, isMemRead_EM, isMemWrite_EM, isHalt_EM  input  1 each  EM control bits.
REQ-008 SHALL have port writeRegSel_EM  input  REG_W  destination register.
REQ-009 SHALL have port ALURes_EM, pcInc_EM  input  DATA_W each  ALU result / memory address; PC+2.
REQ-010 SHALL have port wbSel_EM  input  2  writeback source: 00 ALU, 01 memory, 10 pcInc, 11 reserved (treated as ALU).
REQ-011 SHALL have port memDone, memErr  input  1 each  data-memory access complete; access faulted (valid only with memDone).
REQ-012 SHALL have port memDataOut  input  DATA_W  read data, valid when memDone.
REQ-013 SHALL have port stall_EM  output  1  holds IF/ID/EX/EM upstream when 1.
REQ-014 SHALL have ports valid_MW, isRegWrite_MW, isHalt_MW, err_MW (output 1 each), writeRegSel_MW (output REG_W), writeData (output DATA_W)  registered MW stage.
REQ-015 SHALL have port instCount  output  CNT_W  count of retired instructions.

Function
REQ-016 SHALL implement a three-state FSM: RUN, WAIT, HALT.
REQ-017 SHALL define memop = valid_EM & (isMemRead_EM | isMemWrite_EM) & ~isHalt_EM.
REQ-018 RUN, memop=0 or memDone=1: on the next edge, latch the EM instruction into MW, stall_EM=0, and stay in RUN.
REQ-019 RUN, memop=1 and memDone=0: stall_EM=1 (combinational, same cycle); MW becomes a bubble (valid_MW=0, isRegWrite_MW=0); go to WAIT.
REQ-020 WAIT: stall_EM=1 while memDone=0, with MW held as a bubble.
REQ-021 WAIT, memDone=1: stall_EM=0 in that cycle; latch the instruction into MW using memDataOut; return to RUN.
REQ-022 SHALL set writeData to the value selected by wbSel_EM at the latch edge; 01 uses memDataOut, captured only when memDone=1.
REQ-023 Memory fault: if memErr=1 with memDone, SHALL latch err_MW=1 and isRegWrite_MW=0; otherwise err_MW=0.
REQ-024 Halt: a valid isHalt_EM SHALL latch isHalt_MW=1 for exactly one cycle, suppress any memop, and move the FSM to HALT.
REQ-025 HALT: stall_EM=1; all MW outputs are a bubble with isHalt_MW=0; the FSM stays in HALT until rst.
REQ-026 Bubbles: valid_EM=0 SHALL produce valid_MW=0, isRegWrite_MW=0, isHalt_MW=0, err_MW=0; writeRegSel_MW and writeData are don't-care but SHALL be driven 0.
REQ-027 instCount SHALL increment by 1 on each edge that latches a valid instruction with isRegWrite|isMemWrite|isHalt set.
REQ-028 instCount SHALL wrap modulo 2^CNT_W.
REQ-029 SHALL have zero added latency: an instruction with no memop or an immediate memDone reaches MW one edge after sitting in EM.

Reset
REQ-030 rst=1 at an edge SHALL force state RUN, all MW outputs 0 and instCount 0; stall_EM is 0 from the cycle after.
REQ-031 rst SHALL take priority over every other input, including in WAIT (an in-flight access is abandoned) and in HALT.

Verification
REQ-032 ALU write: valid, RegWrite, sel=5, wbSel=00, ALURes=0x1234 -> next cycle isRegWrite_MW=1, writeRegSel_MW=5, writeData=0x1234, instCount=1.
REQ-033 Load, 3-cycle miss: MemRead, wbSel=01, memDone low for 2 cycles then high with data 0xBEEF -> stall_EM=1,1,0; MW bubbles for 2 cycles; then writeData=0xBEEF.
REQ-034 Load fault: memDone=1 with memErr=1 -> err_MW=1, isRegWrite_MW=0, instCount unchanged.
REQ-035 Halt with MemWrite also set -> isHalt_MW=1 for one cycle; the store is not treated as a memop; stall_EM stays 1 afterwards; instCount +1.
REQ-036 rst asserted while in WAIT -> next cycle state RUN, all outputs 0, instCount=0; a later memDone pulse has no effect.
REQ-037 Counter wrap: preload to 2^CNT_W-1 (force), retire one instruction -> instCount=0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: EM-latch fields, data-memory response, and the
// registered MW-latch outputs with the retired-instruction counter.
interface mem_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
);
  // EM latch
  logic              valid_EM;
  logic              isRegWrite_EM;
  logic              isMemRead_EM;
  logic              isMemWrite_EM;
  logic              isHalt_EM;
  logic [REG_W-1:0]  writeRegSel_EM;
  logic [DATA_W-1:0] ALURes_EM;
  logic [DATA_W-1:0] pcInc_EM;
  logic [1:0]        wbSel_EM;

  // data-memory response
  logic              memDone;
  logic              memErr;
  logic [DATA_W-1:0] memDataOut;

  // stage outputs
  logic              stall_EM;
  logic              valid_MW;
  logic              isRegWrite_MW;
  logic              isHalt_MW;
  logic              err_MW;
  logic [REG_W-1:0]  writeRegSel_MW;
  logic [DATA_W-1:0] writeData;
  logic [CNT_W-1:0]  instCount;

  modport master (
    output valid_EM, isRegWrite_EM, isMemRead_EM, isMemWrite_EM, isHalt_EM,
    output writeRegSel_EM, ALURes_EM, pcInc_EM, wbSel_EM,
    output memDone, memErr, memDataOut,
    input  stall_EM, valid_MW, isRegWrite_MW, isHalt_MW, err_MW,
    input  writeRegSel_MW, writeData, instCount
  );

  modport slave (
    input  valid_EM, isRegWrite_EM, isMemRead_EM, isMemWrite_EM, isHalt_EM,
    input  writeRegSel_EM, ALURes_EM, pcInc_EM, wbSel_EM,
    input  memDone, memErr, memDataOut,
    output stall_EM, valid_MW, isRegWrite_MW, isHalt_MW, err_MW,
    output writeRegSel_MW, writeData, instCount
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: waits out data-memory misses by stalling
// upstream, latches the MW writeback record, and counts retired instructions.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  mem_wb_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10
  } state_e;

  state_e            state;
  state_e            stateNext;
  logic              memop;
  logic              haltIn;
  logic              latch;
  logic              fault;
  logic              retire;
  logic [DATA_W-1:0] wbValue;

  // A halt never touches memory, even when a memory bit rides along with it.
  assign memop  = bus.valid_EM & (bus.isMemRead_EM | bus.isMemWrite_EM) & ~bus.isHalt_EM;
  assign haltIn = bus.valid_EM & bus.isHalt_EM;
  assign fault  = memop & bus.memDone & bus.memErr;
  assign retire = latch & bus.valid_EM & ~fault
                & (bus.isRegWrite_EM | bus.isMemWrite_EM | bus.isHalt_EM);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    stateNext    = state;
    bus.stall_EM = 1'b0;
    latch        = 1'b0;
    unique case (state)
      RUN: begin
        if (memop && !bus.memDone) begin
          bus.stall_EM = 1'b1;
          stateNext    = WAIT;
        end else begin
          latch = 1'b1;
        end
      end
      WAIT: begin
        if (bus.memDone) latch = 1'b1;
        else             bus.stall_EM = 1'b1;
      end
      HALT:    bus.stall_EM = 1'b1;
      default: stateNext = RUN;
    endcase
    if (latch) stateNext = haltIn ? HALT : RUN;
  end

  always_comb begin
    wbValue = bus.ALURes_EM;
    unique case (bus.wbSel_EM)
      2'b01:   wbValue = bus.memDone ? bus.memDataOut : {DATA_W{1'b0}};
      2'b10:   wbValue = bus.pcInc_EM;
      default: wbValue = bus.ALURes_EM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  // NOTE: this stage holds only flops (no storage arrays), so every register
  // is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= RUN;
      bus.valid_MW       <= 1'b0;
      bus.isRegWrite_MW  <= 1'b0;
      bus.isHalt_MW      <= 1'b0;
      bus.err_MW         <= 1'b0;
      bus.writeRegSel_MW <= {REG_W{1'b0}};
      bus.writeData      <= {DATA_W{1'b0}};
      bus.instCount      <= {CNT_W{1'b0}};
    end else begin
      state <= stateNext;
      if (latch && bus.valid_EM) begin
        bus.valid_MW       <= 1'b1;
        bus.isRegWrite_MW  <= bus.isRegWrite_EM & ~fault;
        bus.isHalt_MW      <= bus.isHalt_EM;
        bus.err_MW         <= fault;
        bus.writeRegSel_MW <= bus.writeRegSel_EM;
        bus.writeData      <= wbValue;
      end else begin
        // Bubble: stalls, halted cycles and empty EM slots all read as zero.
        bus.valid_MW       <= 1'b0;
        bus.isRegWrite_MW  <= 1'b0;
        bus.isHalt_MW      <= 1'b0;
        bus.err_MW         <= 1'b0;
        bus.writeRegSel_MW <= {REG_W{1'b0}};
        bus.writeData      <= {DATA_W{1'b0}};
      end
      if (retire) bus.instCount <= bus.instCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: transaction-level model of the stage
// driven with random instructions, plus directed cases with literal results.
module tb_mem_wb_stage;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 8;

  typedef struct {
    logic          valid, regWr, memRd, memWr, halt, fault;
    logic [RW-1:0] sel;
    logic [DW-1:0] alu, pcInc, rdData;
    logic [1:0]    wbSel;
    int            lat;
  } inst_t;

  typedef struct {
    logic          valid, regWr, halt, err;
    logic [RW-1:0] sel;
    logic [DW-1:0] data;
    logic [CW-1:0] count;
  } mw_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus();
  mem_wb_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            checks = 0;
  int            errors = 0;
  logic          chkOn  = 1'b0;
  logic          chkStall = 1'b0;
  logic          expStall = 1'b0;
  mw_t           expMw;
  logic [CW-1:0] modelCount = '0;
  logic          halted = 1'b0;
  logic          stallLog[$];
  logic          validLog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chkOn) begin
      if (chkStall) check("stall_EM", 32'(bus.stall_EM), 32'(expStall));
      check("valid_MW",       32'(bus.valid_MW),       32'(expMw.valid));
      check("isRegWrite_MW",  32'(bus.isRegWrite_MW),  32'(expMw.regWr));
      check("isHalt_MW",      32'(bus.isHalt_MW),      32'(expMw.halt));
      check("err_MW",         32'(bus.err_MW),         32'(expMw.err));
      check("writeRegSel_MW", 32'(bus.writeRegSel_MW), 32'(expMw.sel));
      check("writeData",      32'(bus.writeData),      32'(expMw.data));
      check("instCount",      32'(bus.instCount),      32'(expMw.count));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic inst_t nop();
    inst_t r;
    r.valid = 0; r.regWr = 0; r.memRd = 0; r.memWr = 0; r.halt = 0; r.fault = 0;
    r.sel = '0; r.alu = '0; r.pcInc = '0; r.rdData = '0; r.wbSel = 2'b00; r.lat = 0;
    return r;
  endfunction

  function automatic inst_t rand_inst();
    inst_t r;
    r.valid  = ($urandom_range(0, 9) != 0);
    r.regWr  = 1'($urandom);
    r.memRd  = ($urandom_range(0, 2) == 0);
    r.memWr  = ($urandom_range(0, 3) == 0);
    r.halt   = ($urandom_range(0, 49) == 0);
    r.fault  = ($urandom_range(0, 7) == 0);
    r.sel    = RW'($urandom);
    r.alu    = DW'($urandom);
    r.pcInc  = DW'($urandom);
    r.rdData = DW'($urandom);
    r.wbSel  = 2'($urandom);
    // Memory data is only selected by instructions that actually load.
    if (r.wbSel == 2'b01 && !(r.memRd && !r.halt)) r.wbSel = 2'b00;
    r.lat    = $urandom_range(0, 3);
    return r;
  endfunction

  function automatic mw_t bubble();
    mw_t r;
    r.valid = 0; r.regWr = 0; r.halt = 0; r.err = 0;
    r.sel = '0; r.data = '0; r.count = modelCount;
    return r;
  endfunction

  // What the MW latch must hold after an edge that accepts this instruction.
  task automatic predict(input inst_t ins, input logic done, input logic [DW-1:0] mdo,
                         output mw_t r);
    logic memop, fault;
    r = bubble();
    if (ins.valid) begin
      memop   = (ins.memRd | ins.memWr) & ~ins.halt;
      fault   = memop & ins.fault;
      r.valid = 1'b1;
      r.regWr = ins.regWr & ~fault;
      r.halt  = ins.halt;
      r.err   = fault;
      r.sel   = ins.sel;
      case (ins.wbSel)
        2'b01:   r.data = done ? mdo : '0;
        2'b10:   r.data = ins.pcInc;
        default: r.data = ins.alu;
      endcase
      if (!fault && (ins.regWr || ins.memWr || ins.halt)) modelCount = modelCount + 1'b1;
      r.count = modelCount;
    end
  endtask

  task automatic apply(input inst_t ins, input logic done, input logic err,
                       input logic [DW-1:0] mdo, input logic r);
    rst                = r;
    bus.valid_EM       = ins.valid;
    bus.isRegWrite_EM  = ins.regWr;
    bus.isMemRead_EM   = ins.memRd;
    bus.isMemWrite_EM  = ins.memWr;
    bus.isHalt_EM      = ins.halt;
    bus.writeRegSel_EM = ins.sel;
    bus.ALURes_EM      = ins.alu;
    bus.pcInc_EM       = ins.pcInc;
    bus.wbSel_EM       = ins.wbSel;
    bus.memDone        = done;
    bus.memErr         = err;
    bus.memDataOut     = mdo;
  endtask

  // One clock: drive just after an edge, expect stall this cycle and nxt after the edge.
  task automatic cycle(input inst_t ins, input logic done, input logic err,
                       input logic [DW-1:0] mdo, input logic r,
                       input logic stallExp, input logic stallChk, input mw_t nxt);
    apply(ins, done, err, mdo, r);
    expStall = stallExp;
    chkStall = stallChk;
    #2;
    stallLog.push_back(bus.stall_EM);
    @(posedge clk);
    #1;
    expMw = nxt;
    validLog.push_back(bus.valid_MW);
  endtask

  task automatic do_reset(input inst_t ins);
    mw_t z;
    modelCount = '0;
    halted     = 1'b0;
    z          = bubble();
    cycle(ins, 1'($urandom), 1'($urandom), DW'($urandom), 1'b1, 1'b0, 1'b0, z);
  endtask

  // Presents one instruction until it is accepted; abortAt >= 0 resets mid-miss.
  task automatic run_inst(input inst_t ins, input int abortAt);
    mw_t  r;
    logic done;
    if (halted) begin
      cycle(ins, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, 1'b1, 1'b1, bubble());
    end else if (ins.valid && (ins.memRd || ins.memWr) && !ins.halt) begin
      for (int i = 0; i < ins.lat; i++) begin
        if (i == abortAt) begin
          do_reset(ins);
          return;
        end
        cycle(ins, 1'b0, 1'($urandom), DW'($urandom), 1'b0, 1'b1, 1'b1, bubble());
      end
      predict(ins, 1'b1, ins.rdData, r);
      cycle(ins, 1'b1, ins.fault, ins.rdData, 1'b0, 1'b0, 1'b1, r);
    end else begin
      done = 1'($urandom);
      predict(ins, done, ins.rdData, r);
      cycle(ins, done, 1'($urandom), ins.rdData, 1'b0, 1'b0, 1'b1, r);
      if (ins.valid && ins.halt) halted = 1'b1;
    end
  endtask

  initial begin
    inst_t ins;
    mw_t   r;
    int    abortAt;

    apply(nop(), 1'b0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    do_reset(nop());
    chkOn = 1'b1;
    check("reset valid_MW",  32'(bus.valid_MW),  32'd0);
    check("reset writeData", 32'(bus.writeData), 32'd0);
    check("reset instCount", 32'(bus.instCount), 32'd0);

    // ALU write retires with zero added latency.
    ins = nop(); ins.valid = 1; ins.regWr = 1; ins.sel = 3'd5; ins.alu = 16'h1234;
    run_inst(ins, -1);
    check("alu isRegWrite_MW",  32'(bus.isRegWrite_MW),  32'd1);
    check("alu writeRegSel_MW", 32'(bus.writeRegSel_MW), 32'd5);
    check("alu writeData",      32'(bus.writeData),      32'h1234);
    check("alu instCount",      32'(bus.instCount),      32'd1);

    // Load with a three-cycle miss.
    stallLog.delete(); validLog.delete();
    ins = nop(); ins.valid = 1; ins.regWr = 1; ins.memRd = 1; ins.wbSel = 2'b01;
    ins.sel = 3'd3; ins.rdData = 16'hBEEF; ins.lat = 2;
    run_inst(ins, -1);
    check("miss stall0", 32'(stallLog[0]), 32'd1);
    check("miss stall1", 32'(stallLog[1]), 32'd1);
    check("miss stall2", 32'(stallLog[2]), 32'd0);
    check("miss bubble0", 32'(validLog[0]), 32'd0);
    check("miss bubble1", 32'(validLog[1]), 32'd0);
    check("miss valid",   32'(validLog[2]), 32'd1);
    check("miss writeData", 32'(bus.writeData), 32'hBEEF);
    check("miss instCount", 32'(bus.instCount), 32'd2);

    // Faulted load: flagged, no register write, not counted.
    ins.fault = 1; ins.lat = 0;
    run_inst(ins, -1);
    check("fault err_MW",        32'(bus.err_MW),        32'd1);
    check("fault isRegWrite_MW", 32'(bus.isRegWrite_MW), 32'd0);
    check("fault instCount",     32'(bus.instCount),     32'd2);

    // Halt carrying a store bit, with memDone low: must not stall.
    stallLog.delete();
    ins = nop(); ins.valid = 1; ins.halt = 1; ins.memWr = 1; ins.alu = 16'h00A5;
    predict(ins, 1'b0, 16'h0000, r);
    cycle(ins, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, r);
    halted = 1'b1;
    check("halt stall",     32'(stallLog[0]),   32'd0);
    check("halt isHalt_MW", 32'(bus.isHalt_MW), 32'd1);
    check("halt instCount", 32'(bus.instCount), 32'd3);
    run_inst(rand_inst(), -1);
    run_inst(rand_inst(), -1);
    check("halted stall",     32'(stallLog[2]),   32'd1);
    check("halted isHalt_MW", 32'(bus.isHalt_MW), 32'd0);
    check("halted instCount", 32'(bus.instCount), 32'd3);

    // Reset while waiting on memory, then a stray memDone pulse.
    do_reset(nop());
    ins = nop(); ins.valid = 1; ins.regWr = 1; ins.memRd = 1; ins.wbSel = 2'b01;
    ins.sel = 3'd6; ins.rdData = 16'hCAFE; ins.lat = 3;
    run_inst(ins, 1);
    check("wait-reset valid_MW",  32'(bus.valid_MW),  32'd0);
    check("wait-reset instCount", 32'(bus.instCount), 32'd0);
    cycle(nop(), 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, bubble());
    check("stray memDone valid_MW",  32'(bus.valid_MW),  32'd0);
    check("stray memDone writeData", 32'(bus.writeData), 32'd0);
    check("stray memDone instCount", 32'(bus.instCount), 32'd0);

    // Counter wrap at 2^CW.
    for (int i = 0; i < 255; i++) begin
      ins = nop(); ins.valid = 1; ins.regWr = 1; ins.sel = RW'(i); ins.alu = DW'(i);
      run_inst(ins, -1);
    end
    check("count top", 32'(bus.instCount), 32'd255);
    ins = nop(); ins.valid = 1; ins.memWr = 1; ins.lat = 1;
    run_inst(ins, -1);
    check("count wrap", 32'(bus.instCount), 32'd0);

    // Random instruction stream with occasional resets, including mid-miss.
    for (int n = 0; n < 1500; n++) begin
      ins = rand_inst();
      if (halted) begin
        run_inst(ins, -1);
        if ($urandom_range(0, 3) == 0) do_reset(rand_inst());
      end else if ($urandom_range(0, 49) == 0) begin
        do_reset(ins);
      end else begin
        abortAt = -1;
        if (ins.lat > 0 && $urandom_range(0, 9) == 0) abortAt = $urandom_range(0, ins.lat - 1);
        run_inst(ins, abortAt);
      end
    end

    @(negedge clk);
    chkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
